// File: rtl/seg_pkg.sv
// Shared seven-segment constants: active-low segment type, blank pattern,
// the 0-F glyph table and a width helper.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Segment order {a,b,c,d,e,f,g}, active low.
  localparam seg_t SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-atomic value shadowing and
// leading-zero blanking. Optional anti-ghost gap: define SEG_GHOST_BLANK_EN.
module seven_seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   anode,
  output seg_t                    cathode,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam int PRE_W = clog2(REFRESH_DIV);

`ifdef SEG_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic [PRE_W-1:0]        presc_reg;
  logic [IDX_W-1:0]        index_reg;
  logic [4*NUM_DIGITS-1:0] pend_value_reg, act_value_reg;
  logic [NUM_DIGITS-1:0]   pend_dp_reg, act_dp_reg;
  logic [NUM_DIGITS-1:0]   pend_en_reg, act_en_reg;

  logic                    slot_end, wrap, gap, lit;
  logic [NUM_DIGITS:0]     upper_zero;
  logic [NUM_DIGITS-1:0]   digit_show;
  logic [NUM_DIGITS-1:0]   anode_next;
  logic [3:0]              cur_nibble;
  seg_t                    cur_seg;

  assign slot_end = (presc_reg == PRE_W'(REFRESH_DIV - 1));
  assign wrap     = slot_end && (index_reg == IDX_W'(NUM_DIGITS - 1));

  // upper_zero[i]: every active nibble at index >= i is zero.
  assign upper_zero[NUM_DIGITS] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign upper_zero[gi] = upper_zero[gi+1] && (act_value_reg[4*gi +: 4] == 4'h0);
      assign digit_show[gi] = act_en_reg[gi] && !(lz_en && (gi != 0) && upper_zero[gi]);
      assign anode_next[gi] = !(lit && (index_reg == IDX_W'(gi)));
    end
  endgenerate

  assign cur_nibble = act_value_reg[{index_reg, 2'b00} +: 4];

  // The gap term folds to zero unless the anti-ghost build is selected.
  assign gap = GHOST && (presc_reg < PRE_W'(BLANK_CYCLES));
  assign lit = digit_show[index_reg] && !gap;

  hex_to_seg u_dec (
    .hex (cur_nibble),
    .seg (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg      <= '0;
      index_reg      <= '0;
      pend_value_reg <= '0;
      pend_dp_reg    <= '0;
      pend_en_reg    <= '0;
      act_value_reg  <= '0;
      act_dp_reg     <= '0;
      act_en_reg     <= '0;
      anode          <= '1;
      cathode        <= SEG_BLANK;
      dp_n           <= 1'b1;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= wrap;
      anode      <= anode_next;
      cathode    <= lit ? cur_seg : SEG_BLANK;
      dp_n       <= !(lit && act_dp_reg[index_reg]);

      if (slot_end) begin
        presc_reg <= '0;
        index_reg <= wrap ? '0 : index_reg + 1'b1;
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end

      if (load) begin
        pend_value_reg <= value;
        pend_dp_reg    <= dp;
        pend_en_reg    <= digit_en;
      end

      // A load landing on the wrap edge bypasses the shadow stage.
      if (wrap) begin
        act_value_reg <= load ? value    : pend_value_reg;
        act_dp_reg    <= load ? dp       : pend_dp_reg;
        act_en_reg    <= load ? digit_en : pend_en_reg;
      end
    end
  end

endmodule
